// File: rtl/ofdm_mem_pkg.sv
// Shared definitions for the openofdm_rx buffer RAMs: read-during-write
// encodings, zero-fill sweep states and the byte-lane merge helper.
// Pure package; no logic of its own.
package ofdm_mem_pkg;

  // Same-port read-during-write behaviour.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word / most lanes the merge helper handles.
  localparam int MERGE_MAX_DW = 256;
  localparam int MERGE_MAX_NB = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  // Lanes with a set enable take new_word, the rest keep old_word.
  // Callers zero-extend into the fixed width and truncate the result.
  function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
    input logic [MERGE_MAX_DW-1:0] old_word,
    input logic [MERGE_MAX_DW-1:0] new_word,
    input logic [MERGE_MAX_NB-1:0] we,
    input int                      bw
  );
    logic [MERGE_MAX_DW-1:0] res;
    logic [7:0]              bit_idx;
    logic [7:0]              lane_idx;
    res = old_word;
    for (int j = 0; j < MERGE_MAX_DW; j++) begin
      bit_idx  = 8'(j);
      lane_idx = 8'(j / bw);
      if (we[lane_idx]) res[bit_idx] = new_word[bit_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result pipeline: RD_LAT stages of data plus valid.
// Latency RD_LAT cycles from in_valid to out_valid; no backpressure.
// Each stage only loads on a valid, so the output holds its last result.
module ram_rd_pipe #(
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data
);

  logic [RD_LAT-1:0] vld;
  logic [DWIDTH-1:0] dat [RD_LAT];

  // Shift valids every cycle; move data only alongside a valid.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int k = 0; k < RD_LAT; k++) dat[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int k = 1; k < RD_LAT; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/ram_2port_bw.sv
// True dual-port RAM with byte enables, selectable read-during-write,
// RD_LAT-cycle reads with valid strobes, and a hardware zero-fill sweep.
// Ports are ignored while busy; reads already in flight still complete.
module ram_2port_bw
  import ofdm_mem_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 9,
  parameter int BWIDTH   = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     ena,
  input  logic [DWIDTH/BWIDTH-1:0] wea,
  input  logic [AWIDTH-1:0]        addra,
  input  logic [DWIDTH-1:0]        dia,
  output logic [DWIDTH-1:0]        doa,
  output logic                     doa_valid,
  input  logic                     enb,
  input  logic [DWIDTH/BWIDTH-1:0] web,
  input  logic [AWIDTH-1:0]        addrb,
  input  logic [DWIDTH-1:0]        dib,
  output logic [DWIDTH-1:0]        dob,
  output logic                     dob_valid
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("ram_2port_bw: RD_LAT must be 1..3");
  end
  if ((DWIDTH % BWIDTH) != 0) begin : g_bad_bwidth
    $error("ram_2port_bw: DWIDTH must be a multiple of BWIDTH");
  end
  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
    $error("ram_2port_bw: RDW_MODE must be 0..2");
  end
  if (DWIDTH > MERGE_MAX_DW) begin : g_bad_dwidth
    $error("ram_2port_bw: DWIDTH exceeds byte_merge width");
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  sweep_state_t      state;
  logic [AWIDTH-1:0] sweep_addr;

  logic              wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DWIDTH-1:0] old_a, old_b;
  logic [DWIDTH-1:0] own_a, own_b;
  logic [DWIDTH-1:0] base_a, wdat_a;
  logic [DWIDTH-1:0] rdat_a, rdat_b;

  // Port activity; in NO_CHANGE a write cycle suppresses the read entirely.
  assign wr_a = ena && !busy && (|wea);
  assign wr_b = enb && !busy && (|web);
  assign rd_a = ena && !busy && !((RDW_MODE == RDW_NO_CHANGE) && (|wea));
  assign rd_b = enb && !busy && !((RDW_MODE == RDW_NO_CHANGE) && (|web));
  assign same_addr = (addra == addrb);

  assign old_a = mem[addra];
  assign old_b = mem[addrb];

  // Each port's own write merged over the stored word.
  assign own_a = DWIDTH'(byte_merge(MERGE_MAX_DW'(old_a), MERGE_MAX_DW'(dia),
                                    MERGE_MAX_NB'(wea), BWIDTH));
  assign own_b = DWIDTH'(byte_merge(MERGE_MAX_DW'(old_b), MERGE_MAX_DW'(dib),
                                    MERGE_MAX_NB'(web), BWIDTH));

  // On a same-address double write, A is layered over B's merge so A wins
  // shared lanes and B still lands its exclusive lanes; only A then writes.
  assign base_a = (wr_b && same_addr) ? own_b : old_a;
  assign wdat_a = DWIDTH'(byte_merge(MERGE_MAX_DW'(base_a), MERGE_MAX_DW'(dia),
                                     MERGE_MAX_NB'(wea), BWIDTH));

  // Write-first only sees the port's own write; the other port's write is
  // never visible to a same-cycle read.
  assign rdat_a = (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? own_a : old_a;
  assign rdat_b = (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? own_b : old_b;

  // Array update: sweep zeroes one word per cycle, otherwise port writes.
  always_ff @(posedge clock) begin
    if (state == ST_SWEEP) begin
      mem[sweep_addr] <= '0;
    end else begin
      if (wr_b && !(wr_a && same_addr)) mem[addrb] <= own_b;
      if (wr_a) mem[addra] <= wdat_a;
    end
  end

  // Zero-fill sweep: IDLE -> SWEEP on clear, walk every address once, back
  // to IDLE after the last one; clear during a sweep is ignored.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      sweep_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state      <= ST_SWEEP;
            busy       <= 1'b1;
            sweep_addr <= '0;
          end
        end
        ST_SWEEP: begin
          if (sweep_addr == LAST_ADDR) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            sweep_addr <= '0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          sweep_addr <= '0;
        end
      endcase
    end
  end

  ram_rd_pipe #(
    .DWIDTH(DWIDTH),
    .RD_LAT(RD_LAT)
  ) u_pipe_a (
    .clock    (clock),
    .rstn     (rstn),
    .in_valid (rd_a),
    .in_data  (rdat_a),
    .out_valid(doa_valid),
    .out_data (doa)
  );

  ram_rd_pipe #(
    .DWIDTH(DWIDTH),
    .RD_LAT(RD_LAT)
  ) u_pipe_b (
    .clock    (clock),
    .rstn     (rstn),
    .in_valid (rd_b),
    .in_data  (rdat_b),
    .out_valid(dob_valid),
    .out_data (dob)
  );

endmodule

// File: tb/tb_ram_2port_bw.sv
// Directed bench for ram_2port_bw: three instances share stimulus,
// covering READ_FIRST/RD_LAT=2, WRITE_FIRST/RD_LAT=1, NO_CHANGE/RD_LAT=3.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_ram_2port_bw;

  logic        clock;
  logic        rstn;
  logic        clear;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [31:0] dia, dib;

  logic        busy      [3];
  logic [31:0] doa       [3];
  logic        doa_valid [3];
  logic [31:0] dob       [3];
  logic        dob_valid [3];

  int lat [3];
  int checks = 0;
  int fails  = 0;

  ram_2port_bw #(.DWIDTH(32), .AWIDTH(4), .BWIDTH(8), .RD_LAT(2), .RDW_MODE(0)) u_rf (
    .clock(clock), .rstn(rstn), .clear(clear), .busy(busy[0]),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa[0]), .doa_valid(doa_valid[0]),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob[0]), .dob_valid(dob_valid[0])
  );

  ram_2port_bw #(.DWIDTH(32), .AWIDTH(4), .BWIDTH(8), .RD_LAT(1), .RDW_MODE(1)) u_wf (
    .clock(clock), .rstn(rstn), .clear(clear), .busy(busy[1]),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa[1]), .doa_valid(doa_valid[1]),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob[1]), .dob_valid(dob_valid[1])
  );

  ram_2port_bw #(.DWIDTH(32), .AWIDTH(4), .BWIDTH(8), .RD_LAT(3), .RDW_MODE(2)) u_nc (
    .clock(clock), .rstn(rstn), .clear(clear), .busy(busy[2]),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa[2]), .doa_valid(doa_valid[2]),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob[2]), .dob_valid(dob_valid[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of port activity; returns at the first sample after the edge.
  task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                       input logic [31:0] da, input logic eb, input logic [3:0] wb,
                       input logic [3:0] ab, input logic [31:0] db);
    @(negedge clock);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(negedge clock);
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
  endtask

  // Samples k=1..3 after the issue edge: valid only at k==lat for instances
  // in vmask, data checked at k==lat (a hold value when no valid expected).
  task automatic observe(input string tag, input logic p, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [2:0] vmask);
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        logic        v;
        logic [31:0] d;
        v = p ? dob_valid[i] : doa_valid[i];
        d = p ? dob[i] : doa[i];
        chk($sformatf("%s i%0d k%0d valid", tag, i, k), 32'(v),
            32'(vmask[i] && (k == lat[i])));
        if (k == lat[i]) chk($sformatf("%s i%0d data", tag, i), d, e[i]);
      end
    end
  endtask

  task automatic wr(input logic p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    if (p) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, we, a, d);
    else   drive(1'b1, we, a, d, 1'b0, 4'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clock);
  endtask

  task automatic rd(input string tag, input logic p, input logic [3:0] a, input logic [31:0] e);
    if (p) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, a, 32'h0);
    else   drive(1'b1, 4'h0, a, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    observe(tag, p, e, e, e, 3'b111);
  endtask

  initial begin
    logic [3:0] ad;
    int         nb [3];
    int         nv;

    lat[0] = 2; lat[1] = 1; lat[2] = 3;
    rstn = 1'b1; clear = 1'b0;
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    addra = 4'h0; addrb = 4'h0; dia = 32'h0; dib = 32'h0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset doa i%0d", i), doa[i], 32'h0);
      chk($sformatf("reset doa_valid i%0d", i), 32'(doa_valid[i]), 32'h0);
      chk($sformatf("reset dob_valid i%0d", i), 32'(dob_valid[i]), 32'h0);
      chk($sformatf("reset busy i%0d", i), 32'(busy[i]), 32'h0);
    end
    rstn = 1'b1;

    // Basic write then read with per-instance latency.
    wr(1'b0, 4'd5, 32'hDEADBEEF, 4'hF);
    rd("read5", 1'b0, 4'd5, 32'hDEADBEEF);

    // Byte enables on port B over a full word.
    wr(1'b0, 4'd7, 32'h11223344, 4'hF);
    wr(1'b1, 4'd7, 32'hAABBCCDD, 4'b0101);
    rd("bytewe7", 1'b1, 4'd7, 32'h11BB33DD);

    // Same-port read during write; NO_CHANGE holds its last read (0xDEADBEEF).
    wr(1'b0, 4'd3, 32'h0, 4'hF);
    drive(1'b1, 4'hF, 4'd3, 32'h55, 1'b0, 4'h0, 4'h0, 32'h0);
    observe("rdw3", 1'b0, 32'h0, 32'h55, 32'hDEADBEEF, 3'b011);
    rd("rdw3_after", 1'b0, 4'd3, 32'h55);

    // Double write to one address: A wins lane 1, B owns lane 2, lane 3 kept.
    wr(1'b0, 4'd9, 32'h12345678, 4'hF);
    drive(1'b1, 4'b0011, 4'd9, 32'hAAAAAAAA, 1'b1, 4'b0110, 4'd9, 32'hBBBBBBBB);
    repeat (3) @(negedge clock);
    rd("collide9", 1'b0, 4'd9, 32'h12BBAAAA);

    // A writes while B reads the same address: B sees the old word.
    drive(1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b1, 4'h0, 4'd9, 32'h0);
    observe("xport9", 1'b1, 32'h12BBAAAA, 32'h12BBAAAA, 32'h12BBAAAA, 3'b111);
    rd("xport9_after", 1'b0, 4'd9, 32'hCAFEF00D);

    // Full sweep with ena held high and a second clear mid-sweep.
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      wr(1'b0, ad, {28'hC0DE000, ad}, 4'hF);
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    nb[0] = 0; nb[1] = 0; nb[2] = 0; nv = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy[i]) begin
          nb[i]++;
          if (doa_valid[i]) nv++;
        end
      end
      clear = (c == 5);
      ena   = busy[0];
      addra = 4'(c);
      @(negedge clock);
    end
    clear = 1'b0; ena = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("sweep busy cycles i%0d", i), 32'(nb[i]), 32'd16);
    chk("sweep valids while busy", 32'(nv), 32'd0);
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      rd($sformatf("swept%0d", a), 1'b0, ad, 32'h0);
    end

    // Reset after six swept addresses leaves the rest untouched.
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      wr(1'b1, ad, {28'h5A5A000, ad}, 4'hF);
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (6) @(negedge clock);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("midreset busy i%0d", i), 32'(busy[i]), 32'h0);
    @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) chk($sformatf("postreset busy i%0d", i), 32'(busy[i]), 32'h0);
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      rd($sformatf("partial%0d", a), 1'b0, ad, (a < 6) ? 32'h0 : {28'h5A5A000, ad});
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
